// File: rtl/conway_pkg.sv
// Shared types and constants for the pattern loader: FSM states, pattern_sel
// encodings, the cell-address layout and the built-in pattern lengths.
package conway_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_LOAD = 2'd1,
        FSM_RUN  = 2'd2,
        FSM_DONE = 2'd3
    } fsm_state_e;

    localparam logic [1:0] S_IDLE = FSM_IDLE;
    localparam logic [1:0] S_LOAD = FSM_LOAD;
    localparam logic [1:0] S_RUN  = FSM_RUN;
    localparam logic [1:0] S_DONE = FSM_DONE;

    typedef enum logic [1:0] {
        SEL_GLIDER  = 2'd0,
        SEL_BLINKER = 2'd1,
        SEL_BLOCK   = 2'd2,
        SEL_EXT     = 2'd3
    } pattern_sel_e;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } cell_addr_t;

    localparam int GLIDER_LEN  = 5;
    localparam int BLINKER_LEN = 3;
    localparam int BLOCK_LEN   = 4;
    localparam int EMPTY_LEN   = 0;

    function automatic int pattern_len(input logic [1:0] sel);
        case (sel)
            SEL_GLIDER:  return GLIDER_LEN;
            SEL_BLINKER: return BLINKER_LEN;
            SEL_BLOCK:   return BLOCK_LEN;
            default:     return EMPTY_LEN;
        endcase
    endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// Host-side bus of the pattern loader; the ext_* streaming signals exist only
// when PATTERN_LOADER_EXT_EN is defined.
interface pattern_loader_if #(
    parameter int GEN_W = 8
);
    logic             start;
    logic             abort;
    logic [1:0]       pattern_sel;
    logic [GEN_W-1:0] gen_limit;
    logic             next_gen;
    logic             state;
    logic [15:0]      addr;
    logic             addr_valid;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;
`ifdef PATTERN_LOADER_EXT_EN
    logic             ext_valid;
    logic [15:0]      ext_addr;
    logic             ext_last;
    logic             ext_ready;

    modport slave (
        input  start, abort, pattern_sel, gen_limit, next_gen,
        input  ext_valid, ext_addr, ext_last,
        output state, addr, addr_valid, busy, done, gen_count, ext_ready
    );

    modport master (
        output start, abort, pattern_sel, gen_limit, next_gen,
        output ext_valid, ext_addr, ext_last,
        input  state, addr, addr_valid, busy, done, gen_count, ext_ready
    );
`else
    modport slave (
        input  start, abort, pattern_sel, gen_limit, next_gen,
        output state, addr, addr_valid, busy, done, gen_count
    );

    modport master (
        output start, abort, pattern_sel, gen_limit, next_gen,
        input  state, addr, addr_valid, busy, done, gen_count
    );
`endif
endinterface

// File: rtl/pattern_rom.sv
// Combinational lookup of built-in pattern cells: (sel, index) -> (addr, last).
module pattern_rom
    import conway_pkg::*;
#(
    parameter int MAX_CELLS = 8,
    localparam int IDX_W = (MAX_CELLS > 1) ? $clog2(MAX_CELLS) : 1
) (
    input  logic [1:0]       sel,
    input  logic [IDX_W-1:0] index,
    output cell_addr_t       addr,
    output logic             last
);

    int len;

    always_comb begin
        addr = '0;
        len  = pattern_len(sel);
        case (sel)
            SEL_GLIDER: begin
                case (int'(index))
                    0:       addr = 16'h02ff;
                    1:       addr = 16'h01fd;
                    2:       addr = 16'h02fd;
                    3:       addr = 16'h03fd;
                    4:       addr = 16'h03fe;
                    default: addr = '0;
                endcase
            end
            SEL_BLINKER: begin
                case (int'(index))
                    0:       addr = 16'h0110;
                    1:       addr = 16'h0111;
                    2:       addr = 16'h0112;
                    default: addr = '0;
                endcase
            end
            SEL_BLOCK: begin
                case (int'(index))
                    0:       addr = 16'h0808;
                    1:       addr = 16'h0809;
                    2:       addr = 16'h0908;
                    3:       addr = 16'h0909;
                    default: addr = '0;
                endcase
            end
            default: addr = '0;
        endcase
        // An empty pattern reports last on index 0 so LOAD lasts one cycle.
        last = (len == 0) || (int'(index) == len - 1);
    end

endmodule

// File: rtl/pattern_loader.sv
// Loads a Game-of-Life seed pattern one cell per cycle, then counts engine
// generations. Define PATTERN_LOADER_EXT_EN to stream pattern_sel=3 from ext_*.
module pattern_loader
    import conway_pkg::*;
#(
    parameter int GEN_W     = 8,
    parameter int MAX_CELLS = 8,
    localparam int IDX_W = (MAX_CELLS > 1) ? $clog2(MAX_CELLS) : 1
) (
    input logic             clk,
    input logic             rst,
    pattern_loader_if.slave bus
);

    logic [1:0]       fsm_q;
    logic [1:0]       sel_q;
    logic [GEN_W-1:0] limit_q;
    logic [GEN_W-1:0] count_q;
    logic [GEN_W-1:0] count_inc;
    logic [IDX_W-1:0] idx_q;
    logic             next_gen_q;
    logic             gen_rise;

    cell_addr_t rom_addr;
    logic       rom_last;
    cell_addr_t cell_addr;
    logic       cell_valid;
    logic       load_end;
    logic       in_load;

    pattern_rom #(.MAX_CELLS(MAX_CELLS)) u_rom (
        .sel   (sel_q),
        .index (idx_q),
        .addr  (rom_addr),
        .last  (rom_last)
    );

`ifdef PATTERN_LOADER_EXT_EN
    logic ext_ready;
    assign bus.ext_ready = ext_ready;
`endif

    always_comb begin
        in_load    = (fsm_q == S_LOAD);
        cell_valid = in_load && (sel_q != SEL_EXT);
        cell_addr  = rom_addr;
        load_end   = in_load && rom_last;
`ifdef PATTERN_LOADER_EXT_EN
        ext_ready = in_load && (sel_q == SEL_EXT);
        if (sel_q == SEL_EXT) begin
            cell_valid = bus.ext_valid && ext_ready;
            cell_addr  = bus.ext_addr;
            load_end   = cell_valid && bus.ext_last;
        end
`endif
    end

    assign gen_rise  = bus.next_gen && !next_gen_q;
    assign count_inc = count_q + 1'b1;

    assign bus.addr       = cell_valid ? cell_addr : 16'h0000;
    assign bus.addr_valid = cell_valid;
    assign bus.state      = (fsm_q == S_RUN);
    assign bus.busy       = (fsm_q == S_LOAD) || (fsm_q == S_RUN);
    assign bus.done       = (fsm_q == S_DONE);
    assign bus.gen_count  = count_q;

    // Abort wins over everything; gen_count is only cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= S_IDLE;
            sel_q      <= '0;
            limit_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            next_gen_q <= 1'b0;
        end else begin
            next_gen_q <= bus.next_gen;
            if (bus.abort) begin
                fsm_q <= S_IDLE;
            end else begin
                case (fsm_q)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            sel_q   <= bus.pattern_sel;
                            limit_q <= bus.gen_limit;
                            count_q <= '0;
                            idx_q   <= '0;
                            fsm_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (load_end) begin
                            fsm_q <= S_RUN;
                        end else if (cell_valid) begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (gen_rise) begin
                            count_q <= count_inc;
                            if ((limit_q != '0) && (count_inc == limit_q)) begin
                                fsm_q <= S_DONE;
                            end
                        end
                    end
                    default: fsm_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader: table-driven pattern loads, directed
// corner sequences and randomized runs checked against a generation-count model.
module tb_pattern_loader;

    typedef struct {
        logic [1:0] sel;
        int         first;
        int         len;
    } load_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_tbl;

    logic [15:0] pat_cells [12] = '{
        16'h02ff, 16'h01fd, 16'h02fd, 16'h03fd, 16'h03fe,
        16'h0110, 16'h0111, 16'h0112,
        16'h0808, 16'h0809, 16'h0908, 16'h0909
    };
    load_vec_t tbl [4];

`ifdef PATTERN_LOADER_EXT_EN
    logic [15:0] ext_cells [3] = '{16'h0a0b, 16'h1c1d, 16'h2e2f};
`endif

    always #5 clk = ~clk;

    pattern_loader_if #(.GEN_W(8)) bus ();

    pattern_loader #(.GEN_W(8), .MAX_CELLS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] sel, input logic [7:0] limit);
        bus.pattern_sel = sel;
        bus.gen_limit   = limit;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_output(input string name, input logic st, input logic av,
                                input logic bsy, input logic dn);
        check({name, "_state"}, 32'(bus.state), 32'(st));
        check({name, "_addr_valid"}, 32'(bus.addr_valid), 32'(av));
        check({name, "_busy"}, 32'(bus.busy), 32'(bsy));
        check({name, "_done"}, 32'(bus.done), 32'(dn));
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic pulse_gen(input int n);
        repeat (n) begin
            bus.next_gen = 1'b1;
            tick();
            bus.next_gen = 1'b0;
            tick();
        end
    endtask

    // Start a pattern and follow it through LOAD into RUN.
    task automatic run_load(input load_vec_t v, input logic [7:0] limit);
        apply_stimulus(v.sel, limit);
        if (v.len == 0) begin
            check_output("empty_load", 1'b0, 1'b0, 1'b1, 1'b0);
            check("empty_addr", 32'(bus.addr), 32'h0);
            tick();
        end
        for (int i = 0; i < v.len; i++) begin
            check("cell_addr", 32'(bus.addr), 32'(pat_cells[v.first + i]));
            check_output("cell", 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        check_output("enter_run", 1'b1, 1'b0, 1'b1, 1'b0);
        check("enter_run_addr", 32'(bus.addr), 32'h0);
        check("enter_run_count", 32'(bus.gen_count), 32'h0);
    endtask

    task automatic random_run();
        load_vec_t  v;
        logic [7:0] limit;
        int         n;
        int         rises;
        int         exp_cnt;
        logic       prev;
        logic       exp_done;
        v     = tbl[$urandom_range(0, n_tbl - 1)];
        limit = 8'($urandom_range(0, 5));
        n     = $urandom_range(4, 30);
        rises = 0;
        prev  = 1'b0;
        run_load(v, limit);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            bus.next_gen = b;
            if (b && !prev) rises++;
            prev = b;
            tick();
        end
        bus.next_gen = 1'b0;
        tick();
        if (limit == 8'd0) begin
            exp_cnt  = rises % 256;
            exp_done = 1'b0;
        end else begin
            exp_cnt  = (rises < int'(limit)) ? rises : int'(limit);
            exp_done = (rises >= int'(limit));
        end
        check("rand_count", 32'(bus.gen_count), 32'(exp_cnt));
        check_output("rand_end", !exp_done, 1'b0, !exp_done, exp_done);
        if (!exp_done || ($urandom_range(0, 1) == 1)) begin
            do_abort();
            check_output("rand_abort", 1'b0, 1'b0, 1'b0, 1'b0);
            check("rand_abort_count", 32'(bus.gen_count), 32'(exp_cnt));
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 0, 5};
        tbl[1] = '{2'd1, 5, 3};
        tbl[2] = '{2'd2, 8, 4};
        tbl[3] = '{2'd3, 0, 0};
`ifdef PATTERN_LOADER_EXT_EN
        n_tbl = 3;
        bus.ext_valid = 1'b0;
        bus.ext_addr  = 16'h0;
        bus.ext_last  = 1'b0;
`else
        n_tbl = 4;
`endif
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.pattern_sel = 2'd0;
        bus.gen_limit   = 8'd0;
        bus.next_gen    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_addr", 32'(bus.addr), 32'h0);
        check("reset_count", 32'(bus.gen_count), 32'h0);
        rst = 1'b1;
        tick();
        check_output("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < n_tbl; i++) begin
            run_load(tbl[i], 8'd0);
            do_abort();
            check_output("tbl_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Glider with a limit of four generations.
        run_load(tbl[0], 8'd4);
        pulse_gen(3);
        check("lim_count3", 32'(bus.gen_count), 32'd3);
        check_output("lim_run", 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_gen(1);
        check("lim_count4", 32'(bus.gen_count), 32'd4);
        check_output("lim_done", 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_gen(2);
        check("done_hold_count", 32'(bus.gen_count), 32'd4);
        check_output("done_hold", 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart from DONE; a held next_gen counts once.
        run_load(tbl[1], 8'd0);
        bus.next_gen = 1'b1;
        repeat (10) tick();
        bus.next_gen = 1'b0;
        tick();
        check("held_count", 32'(bus.gen_count), 32'd1);
        pulse_gen(2);
        do_abort();
        check_output("run_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        check("run_abort_count", 32'(bus.gen_count), 32'd3);

        // Abort and start together in LOAD: abort wins, start is dropped.
        apply_stimulus(2'd0, 8'd4);
        check("ab_pre_valid", 32'(bus.addr_valid), 32'd1);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_output("ab_st", 1'b0, 1'b0, 1'b0, 1'b0);
        check("ab_st_addr", 32'(bus.addr), 32'h0);
        tick();
        check_output("ab_st_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Unlimited run wraps modulo 256.
        run_load(tbl[2], 8'd0);
        pulse_gen(257);
        check("wrap_count", 32'(bus.gen_count), 32'd1);
        check_output("wrap_run", 1'b1, 1'b0, 1'b1, 1'b0);
        do_abort();

        // Reset during the third glider cell.
        apply_stimulus(2'd0, 8'd4);
        tick();
        tick();
        check("rst_mid_cell", 32'(bus.addr), 32'h02fd);
        rst = 1'b0;
        #1;
        check_output("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_addr", 32'(bus.addr), 32'h0);
        check("rst_mid_count", 32'(bus.gen_count), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_output("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PATTERN_LOADER_EXT_EN
        begin
            int ci;
            int nvalid;
            ci     = 0;
            nvalid = 0;
            apply_stimulus(2'd3, 8'd0);
            for (int c = 1; c <= 5; c++) begin
                logic gap;
                gap = (c == 2) || (c == 4);
                bus.ext_valid = !gap;
                bus.ext_addr  = gap ? 16'hdead : ext_cells[ci];
                bus.ext_last  = !gap && (ci == 2);
                #1;
                check("ext_ready_load", 32'(bus.ext_ready), 32'd1);
                if (bus.addr_valid) nvalid++;
                if (gap) begin
                    check("ext_gap_valid", 32'(bus.addr_valid), 32'd0);
                    check("ext_gap_addr", 32'(bus.addr), 32'h0);
                end else begin
                    check("ext_cell_addr", 32'(bus.addr), 32'(ext_cells[ci]));
                    ci++;
                end
                tick();
            end
            bus.ext_valid = 1'b0;
            bus.ext_last  = 1'b0;
            #1;
            check("ext_nvalid", 32'(nvalid), 32'd3);
            check("ext_ready_run", 32'(bus.ext_ready), 32'd0);
            check_output("ext_run", 1'b1, 1'b0, 1'b1, 1'b0);
            do_abort();
        end
`else
        run_load(tbl[3], 8'd2);
        pulse_gen(2);
        check_output("empty_done", 1'b0, 1'b0, 1'b0, 1'b1);
        do_abort();
`endif

        for (int k = 0; k < 12; k++) begin
            random_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 The block SHALL have parameter GEN_W, default 8, meaning the width of the generation counter and limit.
REQ-002 The block SHALL have parameter MAX_CELLS, default 8, meaning the maximum number of cells in a built-in pattern.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to load the selected pattern and run it.
REQ-006 The block SHALL have port abort, input, 1 bit: an immediate return to IDLE.
REQ-007 The block SHALL have port pattern_sel, input, 2 bits: 0 glider, 1 blinker, 2 block, 3 empty or external.
REQ-008 The block SHALL have port gen_limit, input, GEN_W bits: the number of generations to run; 0 means run until abort.
REQ-009 The block SHALL have port next_gen, input, 1 bit: the engine's generation-complete level.
REQ-010 The block SHALL have port state, output, 1 bit: the engine mode, 0 load and 1 run.
REQ-011 The block SHALL have port addr, output, 16 bits: the live-cell address, with [15:8] as the upper coordinate and [7:0] as the lower.
REQ-012 The block SHALL have port addr_valid, output, 1 bit: addr is a cell to set this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: the FSM is in LOAD or RUN.
REQ-014 The block SHALL have port done, output, 1 bit: gen_limit generations have completed.
REQ-015 The block SHALL have port gen_count, output, GEN_W bits: the generations counted in the current run.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-017 IDLE and DONE SHALL accept start: capture pattern_sel and gen_limit, clear gen_count and the cell index, then go to LOAD; a start in LOAD or RUN SHALL be ignored.
REQ-018 In LOAD, one pattern cell per cycle SHALL be driven on addr with addr_valid=1 and state=0; the first cell SHALL appear in the cycle after the start edge.
REQ-019 After the last cell, the next cycle SHALL be in RUN with state=1 and addr_valid=0; glider load SHALL therefore take exactly 5 cycles.
REQ-020 A zero-cell pattern SHALL pass through LOAD for exactly one cycle with addr_valid=0, then enter RUN.
REQ-021 In RUN, gen_count SHALL increment by 1 on each 0->1 transition of registered next_gen; a held high level SHALL count once.
REQ-022 In RUN, when the increment makes gen_count equal the captured gen_limit (nonzero), the next state SHALL be DONE with state=0.
REQ-023 With gen_limit=0, gen_count SHALL wrap modulo 2^GEN_W and the block SHALL stay in RUN.
REQ-024 In DONE, done=1 and gen_count SHALL hold until start or abort.
REQ-025 abort SHALL force IDLE on the next edge from any state and SHALL take priority over start in the same cycle; gen_count SHALL be retained.
REQ-026 When addr_valid=0, addr SHALL be 16'h0000.
REQ-027 Built-in patterns SHALL be: glider {02ff,01fd,02fd,03fd,03fe}; blinker {0110,0111,0112}; block {0808,0809,0908,0909}; sel 3 empty.

Reset
REQ-028 Asserting rst low SHALL force, asynchronously: state IDLE, state=0, addr=0, addr_valid=0, busy=0, done=0, gen_count=0, and the next_gen edge register=0.
REQ-029 A reset asserted mid-LOAD or mid-RUN SHALL abandon the operation with no further addr_valid.

Configuration
REQ-030 With PATTERN_LOADER_EXT_EN defined, ports ext_valid (in), ext_addr[15:0] (in), ext_last (in) and ext_ready (out) SHALL exist, and pattern_sel=3 SHALL stream cells from them.
REQ-031 In external mode, ext_ready=1 only in LOAD; a cell transfers when ext_valid&&ext_ready and is forwarded combinationally to addr/addr_valid; a transfer with ext_last SHALL end LOAD; cycles without ext_valid SHALL be stall cycles with addr_valid=0.
REQ-032 Without PATTERN_LOADER_EXT_EN, the external ports SHALL be absent and pattern_sel=3 SHALL be the empty pattern.

Structure
REQ-033 Package conway_pkg SHALL hold the FSM state enum, the pattern_sel encodings, the cell-address typedef, and the pattern lengths.
REQ-034 Sub-module pattern_rom SHALL be a combinational (sel, index) -> (addr, last) lookup.

Verification
REQ-035 Scenario: sel=0, gen_limit=4, start -> addr 02ff,01fd,02fd,03fd,03fe on 5 consecutive cycles; state=1 on the following cycle; after 4 next_gen pulses, done=1, gen_count=4, state=0.
REQ-036 Scenario: sel=3 (macro off), start -> exactly one LOAD cycle with addr_valid=0, then RUN.
REQ-037 Scenario: next_gen held high for 10 cycles in RUN -> gen_count increments by exactly 1.
REQ-038 Scenario: abort and start in the same LOAD cycle -> IDLE next cycle; addr_valid=0; the start is ignored.
REQ-039 Scenario: rst low during the 3rd glider cell -> all outputs zero immediately; after release, the FSM is idle.
REQ-040 Scenario: macro on, sel=3, ext_valid gapped on cycles 2 and 4, 3 cells with ext_last on the third -> 3 addr_valid cycles, then RUN.
